// File: rtl/lfsr_pulse_gen_if.sv
// Bundle of run-control inputs and pulse-stream outputs for lfsr_pulse_gen.
// The master drives stream values and run control; the slave is the generator.
interface lfsr_pulse_gen_if;
    logic       start;
    logic       abort;
    logic       corr;
    logic [6:0] x_val;
    logic [6:0] y_val;
    logic       x_pulse;
    logic       y_pulse;
    logic       busy;
    logic       done;
    logic [7:0] x_cnt;
    logic [7:0] y_cnt;

    modport master (
        output start, abort, corr, x_val, y_val,
        input  x_pulse, y_pulse, busy, done, x_cnt, y_cnt
    );

    modport slave (
        input  start, abort, corr, x_val, y_val,
        output x_pulse, y_pulse, busy, done, x_cnt, y_cnt
    );
endinterface

// File: rtl/lfsr_pulse_gen.sv
// Dual-channel stochastic pulse-stream generator: one full 127-slot LFSR period per run,
// so each channel emits exactly as many pulses as its latched 7-bit value.
module lfsr_pulse_gen #(
    parameter bit         RZ     = 1'b1,
    parameter logic [6:0] SEED_X = 7'h01,
    parameter logic [6:0] SEED_Y = 7'h55
) (
    input  logic               clk,
    input  logic               rst_b,
    lfsr_pulse_gen_if.slave    bus
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t     state_q, state_d;
    logic [6:0] lx_q, lx_d, ly_q, ly_d;
    logic [6:0] xv_q, xv_d, yv_q, yv_d;
    logic       corr_q, corr_d;
    logic [6:0] slot_q, slot_d;
    logic       phase_q, phase_d;
    logic       xp_q, xp_d, yp_q, yp_d;
    logic       done_q, done_d;
    logic [7:0] xc_q, xc_d, yc_q, yc_d;
    logic [6:0] y_src;
    logic       x_hit, y_hit;

    function automatic logic [6:0] lfsr_next(input logic [6:0] q);
        return {q[5:0], q[6] ^ q[5]};
    endfunction

    assign y_src = corr_q ? lx_q : ly_q;
    assign x_hit = (lx_q <= xv_q);
    assign y_hit = (y_src <= yv_q);

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q <= IDLE;
            lx_q    <= SEED_X;
            ly_q    <= SEED_Y;
            xv_q    <= '0;
            yv_q    <= '0;
            corr_q  <= 1'b0;
            slot_q  <= '0;
            phase_q <= 1'b0;
            xp_q    <= 1'b0;
            yp_q    <= 1'b0;
            done_q  <= 1'b0;
            xc_q    <= '0;
            yc_q    <= '0;
        end else begin
            state_q <= state_d;
            lx_q    <= lx_d;
            ly_q    <= ly_d;
            xv_q    <= xv_d;
            yv_q    <= yv_d;
            corr_q  <= corr_d;
            slot_q  <= slot_d;
            phase_q <= phase_d;
            xp_q    <= xp_d;
            yp_q    <= yp_d;
            done_q  <= done_d;
            xc_q    <= xc_d;
            yc_q    <= yc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lx_d    = lx_q;
        ly_d    = ly_q;
        xv_d    = xv_q;
        yv_d    = yv_q;
        corr_d  = corr_q;
        slot_d  = slot_q;
        phase_d = phase_q;
        xp_d    = 1'b0;
        yp_d    = 1'b0;
        done_d  = 1'b0;
        xc_d    = xc_q;
        yc_d    = yc_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    xv_d    = bus.x_val;
                    yv_d    = bus.y_val;
                    corr_d  = bus.corr;
                    lx_d    = SEED_X;
                    ly_d    = SEED_Y;
                    slot_d  = '0;
                    phase_d = 1'b0;
                    xc_d    = '0;
                    yc_d    = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (slot_q == 7'd127) begin
                    // All 127 slots finished: this extra edge closes the run with done.
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (!phase_q) begin
                    xp_d = x_hit;
                    yp_d = y_hit;
                    if (x_hit) xc_d = xc_q + 8'd1;
                    if (y_hit) yc_d = yc_q + 8'd1;
                    lx_d = lfsr_next(lx_q);
                    ly_d = lfsr_next(ly_q);
                    if (RZ) phase_d = 1'b1;
                    else    slot_d  = slot_q + 7'd1;
                end else begin
                    phase_d = 1'b0;
                    slot_d  = slot_q + 7'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.x_pulse = xp_q;
    assign bus.y_pulse = yp_q;
    assign bus.busy    = (state_q == RUN);
    assign bus.done    = done_q;
    assign bus.x_cnt   = xc_q;
    assign bus.y_cnt   = yc_q;

endmodule
